// File: rtl/minmax_pkg.sv
// Shared definitions for the windowed min/max tracker: sample width, window
// limits and the controller state encoding.
package minmax_pkg;

  localparam int unsigned DATA_W  = 4;
  localparam int unsigned LEN_MAX = 15;

  typedef logic [DATA_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/comparator4_behavioral.sv
// Unsigned 4-bit magnitude comparator; exactly one of lt/eq/gt is high.
module comparator4_behavioral (
  output logic       lt,
  output logic       eq,
  output logic       gt,
  input  logic [3:0] a,
  input  logic [3:0] b
);

  always_comb begin
    lt = (a < b);
    eq = (a == b);
    gt = (a > b);
  end

endmodule

// File: rtl/minmax_tracker.sv
// Windowed min/max accumulator: collects LEN 4-bit samples per window and
// reports minimum, maximum and range through a valid/ack result handshake.
module minmax_tracker
  import minmax_pkg::*;
#(
  parameter int unsigned LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ack,
  output logic [DATA_W-1:0] min_out,
  output logic [DATA_W-1:0] max_out,
  output logic [DATA_W-1:0] range_out,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  generate
    if (LEN < 1 || LEN > LEN_MAX) begin : g_len_check
      $error("minmax_tracker: LEN must be in 1..15");
    end
  endgenerate

  state_t           state;
  logic [CNT_W-1:0] cnt;
  sample_t          min_reg;
  sample_t          max_reg;

  logic    lt_min, eq_min, gt_min;
  logic    lt_max, eq_max, gt_max;
  logic    first;
  logic    last;
  logic    xfer;
  sample_t min_next;
  sample_t max_next;
  sample_t range_next;

  comparator4_behavioral u_cmp_min (
    .lt (lt_min),
    .eq (eq_min),
    .gt (gt_min),
    .a  (in_data),
    .b  (min_reg)
  );

  comparator4_behavioral u_cmp_max (
    .lt (lt_max),
    .eq (eq_max),
    .gt (gt_max),
    .a  (in_data),
    .b  (max_reg)
  );

  always_comb begin
    in_ready = (state == ACCUM);
    busy     = (state != IDLE);
  end

  // The first sample of a window seeds both registers regardless of the
  // comparators, which still see the previous window's values.
  always_comb begin
    first      = (cnt == '0);
    last       = (cnt == LAST);
    xfer       = in_valid && in_ready;
    min_next   = min_reg;
    max_next   = max_reg;
    if (first) begin
      min_next = in_data;
      max_next = in_data;
    end else begin
      if (lt_min) min_next = in_data;
      if (gt_max) max_next = in_data;
    end
    range_next = max_next - min_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      min_reg   <= '0;
      max_reg   <= '0;
      min_out   <= '0;
      max_out   <= '0;
      range_out <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ACCUM;
            cnt   <= '0;
          end
        end

        ACCUM: begin
          if (xfer) begin
            min_reg <= min_next;
            max_reg <= max_next;
            cnt     <= cnt + 1'b1;
            if (last) begin
              state     <= DONE;
              min_out   <= min_next;
              max_out   <= max_next;
              range_out <= range_next;
              out_valid <= 1'b1;
            end
          end
        end

        DONE: begin
          if (out_ack) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  a_cmp_onehot : assert property (@(posedge clk) disable iff (rst)
    $onehot({lt_min, eq_min, gt_min}) && $onehot({lt_max, eq_max, gt_max}));

endmodule

// File: tb/tb_minmax_tracker.sv
// Self-checking bench for minmax_tracker: three instances (LEN = 4, 8, 1)
// share the sample stream; expected results are queued per window.
module tb_minmax_tracker;

  localparam int NI = 3;

  logic            clk      = 1'b0;
  logic            rst      = 1'b1;
  logic            in_valid = 1'b0;
  logic [3:0]      in_data  = '0;
  logic            out_ack  = 1'b0;
  logic [NI-1:0]   start    = '0;
  logic [NI-1:0]   in_ready;
  logic [NI-1:0]   out_valid;
  logic [NI-1:0]   busy;
  logic [3:0]      min_o   [NI];
  logic [3:0]      max_o   [NI];
  logic [3:0]      range_o [NI];

  int checks = 0;
  int passed = 0;

  typedef struct {
    int         inst;
    logic [3:0] mn;
    logic [3:0] mx;
    logic [3:0] rg;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  minmax_tracker #(.LEN(4)) u_len4 (
    .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready[0]), .out_valid(out_valid[0]), .out_ack(out_ack),
    .min_out(min_o[0]), .max_out(max_o[0]), .range_out(range_o[0]), .busy(busy[0])
  );

  minmax_tracker #(.LEN(8)) u_len8 (
    .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready[1]), .out_valid(out_valid[1]), .out_ack(out_ack),
    .min_out(min_o[1]), .max_out(max_o[1]), .range_out(range_o[1]), .busy(busy[1])
  );

  minmax_tracker #(.LEN(1)) u_len1 (
    .clk(clk), .rst(rst), .start(start[2]), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready[2]), .out_valid(out_valid[2]), .out_ack(out_ack),
    .min_out(min_o[2]), .max_out(max_o[2]), .range_out(range_o[2]), .busy(busy[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transfer on instance inst; n counts accepted samples.
  task automatic send(input int inst, input logic [3:0] d, inout int n);
    in_valid = 1'b1;
    in_data  = d;
    for (int w = 0; w < 8 && !in_ready[inst]; w++) tick();
    checks++;
    if (in_ready[inst] !== 1'b1)
      $display("FAIL send_ready inst=%0d got=%b exp=1", inst, in_ready[inst]);
    else begin
      passed++;
      n++;
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Opens a window, streams the samples (optionally with bubbles during which
  // start is also pulsed), then checks latency and the scoreboarded result.
  task automatic run_window(input int inst, input logic [3:0] s[$],
                            input int bubbles, input bit do_ack);
    exp_t e;
    exp_t got;
    int   n = 0;
    e.inst = inst;
    e.mn   = s[0];
    e.mx   = s[0];
    foreach (s[k]) begin
      if (s[k] < e.mn) e.mn = s[k];
      if (s[k] > e.mx) e.mx = s[k];
    end
    e.rg = e.mx - e.mn;
    sb.push_back(e);

    start[inst] = 1'b1;
    tick();
    start[inst] = 1'b0;
    checks++;
    if (busy[inst] !== 1'b1) $display("FAIL win_busy inst=%0d got=%b exp=1", inst, busy[inst]);
    else passed++;

    foreach (s[k]) begin
      if (k > 0) begin
        for (int b = 0; b < bubbles; b++) begin
          in_valid     = 1'b0;
          in_data      = 4'($urandom);
          start[inst]  = 1'b1;
          tick();
        end
        start[inst] = 1'b0;
      end
      checks++;
      if (out_valid[inst] !== 1'b0)
        $display("FAIL early_valid inst=%0d sample=%0d got=%b exp=0", inst, k, out_valid[inst]);
      else passed++;
      send(inst, s[k], n);
    end

    checks++;
    if (n != s.size()) $display("FAIL xfer_count inst=%0d got=%0d exp=%0d", inst, n, s.size());
    else passed++;

    checks++;
    if (out_valid[inst] !== 1'b1)
      $display("FAIL latency inst=%0d out_valid got=%b exp=1", inst, out_valid[inst]);
    else passed++;

    if (out_valid[inst] === 1'b1) begin
      checks++;
      if (sb.size() == 0) $display("FAIL sb_empty inst=%0d got=0 exp=1 entry", inst);
      else begin
        passed++;
        got = sb.pop_front();
        checks++;
        if (min_o[inst] !== got.mn) $display("FAIL min inst=%0d got=%0d exp=%0d", inst, min_o[inst], got.mn);
        else passed++;
        checks++;
        if (max_o[inst] !== got.mx) $display("FAIL max inst=%0d got=%0d exp=%0d", inst, max_o[inst], got.mx);
        else passed++;
        checks++;
        if (range_o[inst] !== got.rg) $display("FAIL range inst=%0d got=%0d exp=%0d", inst, range_o[inst], got.rg);
        else passed++;
      end
    end

    if (do_ack) begin
      out_ack = 1'b1;
      tick();
      out_ack = 1'b0;
      checks++;
      if (busy[inst] !== 1'b0 || out_valid[inst] !== 1'b0)
        $display("FAIL ack_idle inst=%0d busy=%b out_valid=%b exp=0/0", inst, busy[inst], out_valid[inst]);
      else passed++;
      checks++;
      if (min_o[inst] !== e.mn || max_o[inst] !== e.mx)
        $display("FAIL idle_hold inst=%0d min=%0d max=%0d exp=%0d/%0d", inst, min_o[inst], max_o[inst], e.mn, e.mx);
      else passed++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'($urandom);
      in_data  = 4'($urandom);
      start    = 3'($urandom);
      out_ack  = 1'($urandom);
      tick();
    end
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (in_ready[i] !== 1'b0 || out_valid[i] !== 1'b0 || busy[i] !== 1'b0)
        $display("FAIL reset_ctrl inst=%0d ready=%b valid=%b busy=%b exp=0/0/0",
                 i, in_ready[i], out_valid[i], busy[i]);
      else passed++;
      checks++;
      if (min_o[i] !== 4'd0 || max_o[i] !== 4'd0 || range_o[i] !== 4'd0)
        $display("FAIL reset_data inst=%0d min=%0d max=%0d range=%0d exp=0/0/0",
                 i, min_o[i], max_o[i], range_o[i]);
      else passed++;
    end
    in_valid = 1'b0;
    start    = '0;
    out_ack  = 1'b0;
    rst      = 1'b0;
    tick();
    checks++;
    if (busy !== '0) $display("FAIL post_reset_busy got=%b exp=000", busy);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] q[$];
    q = '{4'd5, 4'd2, 4'd9, 4'd2};
    run_window(0, q, 0, 1'b1);
  endtask

  task automatic test_bubbles();
    logic [3:0] q[$];
    q = '{4'd7, 4'd7, 4'd7, 4'd7};
    run_window(0, q, 2, 1'b1);
  endtask

  task automatic test_hold_and_ack();
    logic [3:0] q[$];
    q = '{4'd15, 4'd3, 4'd0, 4'd8, 4'd15, 4'd1, 4'd0, 4'd12};
    run_window(1, q, 0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      start[1] = (c % 2 == 0);
      in_valid = 1'b1;
      tick();
      checks++;
      if (out_valid[1] !== 1'b1 || busy[1] !== 1'b1 || in_ready[1] !== 1'b0)
        $display("FAIL done_hold_ctrl cyc=%0d valid=%b busy=%b ready=%b exp=1/1/0",
                 c, out_valid[1], busy[1], in_ready[1]);
      else passed++;
      checks++;
      if (min_o[1] !== 4'd0 || max_o[1] !== 4'd15 || range_o[1] !== 4'd15)
        $display("FAIL done_hold_data cyc=%0d min=%0d max=%0d range=%0d exp=0/15/15",
                 c, min_o[1], max_o[1], range_o[1]);
      else passed++;
    end
    in_valid = 1'b0;
    out_ack  = 1'b1;
    start[1] = 1'b1;
    tick();
    out_ack  = 1'b0;
    start[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      checks++;
      if (busy[1] !== 1'b0 || in_ready[1] !== 1'b0)
        $display("FAIL ack_beats_start cyc=%0d busy=%b ready=%b exp=0/0", c, busy[1], in_ready[1]);
      else passed++;
      tick();
    end
    in_valid = 1'b0;
    q = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
    run_window(1, q, 0, 1'b1);
  endtask

  task automatic test_reset_abort();
    logic [3:0] q[$];
    int         n = 0;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    send(0, 4'd4, n);
    send(0, 4'd11, n);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0)
      $display("FAIL abort_ctrl ready=%b valid=%b busy=%b exp=0/0/0", in_ready[0], out_valid[0], busy[0]);
    else passed++;
    checks++;
    if (min_o[0] !== 4'd0 || max_o[0] !== 4'd0 || range_o[0] !== 4'd0)
      $display("FAIL abort_data min=%0d max=%0d range=%0d exp=0/0/0", min_o[0], max_o[0], range_o[0]);
    else passed++;
    tick();
    rst = 1'b0;
    tick();
    q = '{4'd1, 4'd1, 4'd1, 4'd1};
    run_window(0, q, 0, 1'b1);
  endtask

  task automatic test_len1();
    logic [3:0] q[$];
    q = '{4'd6};
    run_window(2, q, 0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_bubbles();
    test_hold_and_ack();
    test_reset_abort();
    test_len1();
    checks++;
    if (sb.size() != 0) $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
